// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath widths, the hard-wired zero register and
// symbolic register indices used by control, the RegDst mux and the register file.
package mips_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_CNT_W  = 16;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [4:0] {
        REG_ZERO = 5'd0,
        REG_AT   = 5'd1,
        REG_V0   = 5'd2,
        REG_V1   = 5'd3,
        REG_A0   = 5'd4,
        REG_A1   = 5'd5,
        REG_A2   = 5'd6,
        REG_A3   = 5'd7,
        REG_T0   = 5'd8,
        REG_T1   = 5'd9,
        REG_T2   = 5'd10,
        REG_T3   = 5'd11,
        REG_T4   = 5'd12,
        REG_T5   = 5'd13,
        REG_T6   = 5'd14,
        REG_T7   = 5'd15,
        REG_S0   = 5'd16,
        REG_S1   = 5'd17,
        REG_S2   = 5'd18,
        REG_S3   = 5'd19,
        REG_S4   = 5'd20,
        REG_S5   = 5'd21,
        REG_S6   = 5'd22,
        REG_S7   = 5'd23,
        REG_T8   = 5'd24,
        REG_T9   = 5'd25,
        REG_K0   = 5'd26,
        REG_K1   = 5'd27,
        REG_GP   = 5'd28,
        REG_SP   = 5'd29,
        REG_FP   = 5'd30,
        REG_RA   = 5'd31
    } reg_idx_e;

endpackage

// File: rtl/register_file_wb_if.sv
// Write-back, operand-read and debug signals between the pipeline and the register file.
interface register_file_wb_if
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int CNT_W  = DEFAULT_CNT_W
);

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] DbgAddr;
    logic [DATA_W-1:0] DbgData;
    logic [CNT_W-1:0]  WrCount;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgAddr,
        input  ReadData1, ReadData2, DbgData, WrCount
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgAddr,
        output ReadData1, ReadData2, DbgData, WrCount
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational operand read: forces $0 to zero and optionally forwards the
// word being written this cycle so decode sees it without waiting for the edge.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              bypass_ok,
    output logic [DATA_W-1:0] rd_data
);

    logic hit;

    assign hit = BYPASS && bypass_ok && wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_data = stored;
        if (rd_addr == ADDR_W'(ZERO_REG)) begin
            rd_data = '0;
        end else if (hit) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/register_file_wb.sv
// MIPS 32x32 register file fed by the RegDst mux: two combinational operand reads,
// one write port, $0 hard-wired to zero, plus a debug read and a committed-write counter.
module register_file_wb
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    register_file_wb_if.slave bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  wr_count;
    logic              commit;
    logic              bypass_ok;

    // Writes to $0 are dropped entirely, so they neither store nor count.
    assign commit    = !reset && bus.RegWrite && (bus.WriteReg != ADDR_W'(ZERO_REG));
    assign bypass_ok = !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit) begin
            regs[bus.WriteReg] <= bus.WriteData;
            wr_count           <= wr_count + CNT_W'(1);
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_read1 (
        .rd_addr   (bus.ReadReg1),
        .stored    (regs[bus.ReadReg1]),
        .wr_en     (bus.RegWrite),
        .wr_addr   (bus.WriteReg),
        .wr_data   (bus.WriteData),
        .bypass_ok (bypass_ok),
        .rd_data   (bus.ReadData1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_read2 (
        .rd_addr   (bus.ReadReg2),
        .stored    (regs[bus.ReadReg2]),
        .wr_en     (bus.RegWrite),
        .wr_addr   (bus.WriteReg),
        .wr_data   (bus.WriteData),
        .bypass_ok (bypass_ok),
        .rd_data   (bus.ReadData2)
    );

    // The debug view shows committed contents only, never the in-flight write.
    assign bus.DbgData = (bus.DbgAddr == ADDR_W'(ZERO_REG)) ? '0 : regs[bus.DbgAddr];
    assign bus.WrCount = wr_count;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench driving a bypassing and a non-bypassing register file with
// identical stimulus and comparing against hand-computed values.
module tb_register_file_wb;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    register_file_wb_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus_byp ();
    register_file_wb_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus_nob ();

    register_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .CNT_W(16)) dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_byp.slave)
    );

    register_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .CNT_W(16)) dut_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nob.slave)
    );

    task automatic applyStimulus(input logic rw, input logic [4:0] wreg, input logic [31:0] wdata,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        bus_byp.RegWrite = rw;  bus_nob.RegWrite = rw;
        bus_byp.WriteReg = wreg; bus_nob.WriteReg = wreg;
        bus_byp.WriteData = wdata; bus_nob.WriteData = wdata;
        bus_byp.ReadReg1 = r1;  bus_nob.ReadReg1 = r1;
        bus_byp.ReadReg2 = r2;  bus_nob.ReadReg2 = r2;
        bus_byp.DbgAddr = dbg;  bus_nob.DbgAddr = dbg;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_no_bypass_rd1", bus_byp.ReadData1, 32'h0);

        // Reset released: everything reads zero.
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd5);
        #1;
        checkOutput("post_reset_rd1_r5", bus_byp.ReadData1, 32'h0);
        checkOutput("post_reset_rd2_r31", bus_byp.ReadData2, 32'h0);
        checkOutput("post_reset_dbg_r5", bus_byp.DbgData, 32'h0);
        checkOutput("post_reset_wrcount", {16'h0, bus_byp.WrCount}, 32'h0);
        checkOutput("post_reset_wrcount_nob", {16'h0, bus_nob.WrCount}, 32'h0);

        // Write $8 and read it back one cycle later.
        @(negedge clk);
        applyStimulus(1'b1, 5'd8, 32'h1234_5678, 5'd8, 5'd0, 5'd8);
        #1;
        checkOutput("w8_bypass_same_cycle", bus_byp.ReadData1, 32'h1234_5678);
        checkOutput("w8_nobypass_old", bus_nob.ReadData1, 32'h0);
        checkOutput("w8_dbg_old", bus_byp.DbgData, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
        #1;
        checkOutput("r8_rd1_nob", bus_nob.ReadData1, 32'h1234_5678);
        checkOutput("r8_rd2_byp", bus_byp.ReadData2, 32'h1234_5678);
        checkOutput("r8_dbg", bus_byp.DbgData, 32'h1234_5678);
        checkOutput("r8_wrcount", {16'h0, bus_byp.WrCount}, 32'd1);

        // Write to $0 is dropped.
        @(negedge clk);
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("w0_same_cycle_rd1", bus_byp.ReadData1, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 5'd0);
        #1;
        checkOutput("w0_next_rd1", bus_byp.ReadData1, 32'h0);
        checkOutput("w0_next_dbg", bus_nob.DbgData, 32'h0);
        checkOutput("w0_wrcount", {16'h0, bus_byp.WrCount}, 32'd1);
        checkOutput("w0_r8_intact", bus_byp.ReadData2, 32'h1234_5678);

        // Seed $9, then overwrite with both read ports aimed at it.
        @(negedge clk);
        applyStimulus(1'b1, 5'd9, 32'h1111_1111, 5'd0, 5'd0, 5'd9);
        @(negedge clk);
        applyStimulus(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
        #1;
        checkOutput("w9_byp_rd1", bus_byp.ReadData1, 32'hA5A5_A5A5);
        checkOutput("w9_byp_rd2", bus_byp.ReadData2, 32'hA5A5_A5A5);
        checkOutput("w9_byp_dbg_old", bus_byp.DbgData, 32'h1111_1111);
        checkOutput("w9_nob_rd1_old", bus_nob.ReadData1, 32'h1111_1111);
        checkOutput("w9_nob_rd2_old", bus_nob.ReadData2, 32'h1111_1111);
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd8, 5'd9);
        #1;
        checkOutput("r9_nob_rd1", bus_nob.ReadData1, 32'hA5A5_A5A5);
        checkOutput("r9_dbg", bus_byp.DbgData, 32'hA5A5_A5A5);
        checkOutput("r8_rd2_other_reg", bus_nob.ReadData2, 32'h1234_5678);
        checkOutput("r9_wrcount", {16'h0, bus_nob.WrCount}, 32'd3);

        // Reset beats a concurrent write to $31.
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd8, 5'd31);
        #1;
        checkOutput("rst_w31_no_bypass", bus_byp.ReadData1, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd31, 5'd8, 5'd31);
        #1;
        checkOutput("rst_r31", bus_byp.ReadData1, 32'h0);
        checkOutput("rst_r8_cleared", bus_byp.ReadData2, 32'h0);
        checkOutput("rst_dbg31", bus_nob.DbgData, 32'h0);
        checkOutput("rst_wrcount", {16'h0, bus_byp.WrCount}, 32'h0);

        // 65535 writes to $2 bring WrCount to all-ones; one more wraps it.
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 5'd2, i, 5'd2, 5'd1, 5'd2);
        end
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd2, 5'd1, 5'd2);
        #1;
        checkOutput("pre_wrap_wrcount", {16'h0, bus_byp.WrCount}, 32'h0000_FFFF);
        checkOutput("pre_wrap_r2", bus_nob.DbgData, 32'h0000_FFFE);
        @(negedge clk);
        applyStimulus(1'b1, 5'd1, 32'h0BAD_C0DE, 5'd2, 5'd1, 5'd1);
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd2, 5'd1, 5'd1);
        #1;
        checkOutput("wrap_wrcount_byp", {16'h0, bus_byp.WrCount}, 32'h0);
        checkOutput("wrap_wrcount_nob", {16'h0, bus_nob.WrCount}, 32'h0);
        checkOutput("wrap_r1", bus_nob.ReadData2, 32'h0BAD_C0DE);
        checkOutput("wrap_dbg_r1", bus_byp.DbgData, 32'h0BAD_C0DE);
        checkOutput("wrap_r2_kept", bus_byp.ReadData1, 32'h0000_FFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
